mem_arbiter: RTL and testbench

- Shares the single four-bank main memory between two cache controllers: port 0 is the instruction cache FSM and port 1 is the data cache FSM.
- Each requester holds a lock for a whole fill/evict burst. The arbiter forwards only the owner's memory commands and stalls the other requester.
- Ownership changes only once the memory is quiescent, so in-flight bank reads always return to the requester that issued them.
- Sits between both cache FSMs and the memory; neither FSM changes.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/arb_drain_cnt.sv | 37 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-port main-memory arbiter: FSM state
//   encodings, memory bank count and address/data widths.
//   Optional feature macro used by mem_arbiter: MEM_ARB_PERF_CNT_EN.
package mem_arbiter_pkg;

  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN0  = 2'b01,
    ARB_OWN1  = 2'b10,
    ARB_DRAIN = 2'b11
  } arb_state_e;

endpackage

// File: rtl/arb_drain_cnt.sv
// arb_drain_cnt
//   Loadable down-counter with a zero flag. Times the minimum quiet period
//   after an owner releases the memory.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val (has priority over dec)
//   load_val    value to load
//   dec         decrement by one; holds at zero
//   zero        counter is zero
module arb_drain_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the four-bank main memory between the instruction cache (port 0)
//   and data cache (port 1). A port holds req for a whole burst; only the
//   owner's commands reach memory. Ownership only changes after the memory
//   has been quiet for DRAIN_CYC cycles and all banks are idle, so bank
//   reads always return to the requester that issued them.
//   Optional: MEM_ARB_PERF_CNT_EN builds saturating grant/wait counters;
//   without it cnt_grant/cnt_wait are tied to 0.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req/addr/wdata/wr/rd n   requester n burst lock and command
//   gnt n, stall n, err n    requester n ownership, hold and error
//   rdata                    memory read data to both ports
//   m_*                      memory command / status
//   cnt_grant, cnt_wait      performance counters
//   dbg_state                current arbiter FSM state
//
// Handshake: a requester keeps its command stable while its stall is high;
// a command is accepted by the memory in any cycle where the port owns the
// memory (gnt=1) and stall is low.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic                 rd0,
  input  logic                 rd1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 stall0,
  output logic                 stall1,
  output logic [DATA_W-1:0]    rdata,
  output logic                 err0,
  output logic                 err1,
  output logic [ADDR_W-1:0]    m_addr,
  output logic [DATA_W-1:0]    m_data_in,
  output logic                 m_wr,
  output logic                 m_rd,
  input  logic [DATA_W-1:0]    m_data_out,
  input  logic [NUM_BANKS-1:0] m_busy,
  input  logic                 m_stall,
  input  logic                 m_err,
  output logic [CNT_W-1:0]     cnt_grant,
  output logic [CNT_W-1:0]     cnt_wait,
  output logic [1:0]           dbg_state
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  arb_state_e state, next_state;
  logic       last_owner;
  logic       drain_load;
  logic       drain_zero;

  arb_drain_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (drain_load),
    .load_val (DRAIN_W'(DRAIN_CYC - 1)),
    .dec      (state == ARB_DRAIN),
    .zero     (drain_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= next_state;
      if ((state == ARB_OWN0) && !req0) last_owner <= 1'b0;
      if ((state == ARB_OWN1) && !req1) last_owner <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    drain_load = 1'b0;
    case (state)
      ARB_IDLE: begin
        // On a tie the port that did not own last goes first.
        if (req0 && req1)  next_state = last_owner ? ARB_OWN0 : ARB_OWN1;
        else if (req0)     next_state = ARB_OWN0;
        else if (req1)     next_state = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!req0) begin
          next_state = ARB_DRAIN;
          drain_load = 1'b1;
        end
      end
      ARB_OWN1: begin
        if (!req1) begin
          next_state = ARB_DRAIN;
          drain_load = 1'b1;
        end
      end
      ARB_DRAIN: begin
        if (drain_zero && (m_busy == '0)) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Output mux. Stall is gated with rst so both stalls read 0 during reset
  // even though a requester may be holding req.
  always_comb begin
    m_addr    = '0;
    m_data_in = '0;
    m_wr      = 1'b0;
    m_rd      = 1'b0;
    stall0    = req0 & rst;
    stall1    = req1 & rst;
    err0      = 1'b0;
    err1      = 1'b0;
    case (state)
      ARB_OWN0: begin
        m_addr    = addr0;
        m_data_in = wdata0;
        m_wr      = wr0;
        m_rd      = rd0;
        stall0    = m_stall;
        err0      = m_err;
      end
      ARB_OWN1: begin
        m_addr    = addr1;
        m_data_in = wdata1;
        m_wr      = wr1;
        m_rd      = rd1;
        stall1    = m_stall;
        err1      = m_err;
      end
      ARB_DRAIN: begin
        // A late error from the released burst belongs to its issuer.
        if (last_owner) err1 = m_err;
        else            err0 = m_err;
      end
      default: ;
    endcase
  end

  assign gnt0      = (state == ARB_OWN0);
  assign gnt1      = (state == ARB_OWN1);
  assign rdata     = m_data_out;
  assign dbg_state = state;

`ifdef MEM_ARB_PERF_CNT_EN
  logic grant_evt;
  logic wait_evt;

  assign grant_evt = (state == ARB_IDLE) && (next_state != ARB_IDLE);
  assign wait_evt  = (req0 & stall0 & ~gnt0) | (req1 & stall1 & ~gnt1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_grant <= '0;
      cnt_wait  <= '0;
    end else begin
      if (grant_evt && !(&cnt_grant)) cnt_grant <= cnt_grant + 1'b1;
      if (wait_evt && !(&cnt_wait))   cnt_wait  <= cnt_wait + 1'b1;
    end
  end
`else
  assign cnt_grant = '0;
  assign cnt_wait  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios plus a randomized run checked against a behavioural
//   model of ownership (who owns, how long memory has been quiet).
module tb_mem_arbiter;

  localparam int DRAIN_CYC = 4;
  localparam int CNT_W     = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req0, req1, wr0, wr1, rd0, rd1;
  logic [15:0] addr0, addr1, wdata0, wdata1, m_data_out;
  logic [3:0]  m_busy;
  logic        m_stall, m_err;
  logic        gnt0, gnt1, stall0, stall1, err0, err1, m_wr, m_rd;
  logic [15:0] rdata, m_addr, m_data_in;
  logic [CNT_W-1:0] cnt_grant, cnt_wait;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .wr0(wr0), .wr1(wr1),
    .rd0(rd0), .rd1(rd1), .gnt0(gnt0), .gnt1(gnt1),
    .stall0(stall0), .stall1(stall1), .rdata(rdata),
    .err0(err0), .err1(err1), .m_addr(m_addr), .m_data_in(m_data_in),
    .m_wr(m_wr), .m_rd(m_rd), .m_data_out(m_data_out), .m_busy(m_busy),
    .m_stall(m_stall), .m_err(m_err), .cnt_grant(cnt_grant),
    .cnt_wait(cnt_wait), .dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; rd0 = 0; rd1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    m_data_out = 0; m_busy = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0;
    clear_inputs();
    req0 = 1; req1 = 1; m_err = 1; m_data_out = 16'h1234;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({gnt0, gnt1, stall0, stall1, err0, err1, m_wr, m_rd} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {gnt0, gnt1, stall0, stall1, err0, err1, m_wr, m_rd});
    end
    n_vec++;
    if ({m_addr, m_data_in} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: m_addr=%h m_data_in=%h want 0", m_addr, m_data_in);
    end
    n_vec++;
    if (rdata !== 16'h1234) begin
      n_err++;
      $display("FAIL reset_rdata: got %h want 1234", rdata);
    end
    n_vec++;
    if ({cnt_grant, cnt_wait} !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: grant=%0d wait=%0d want 0", cnt_grant, cnt_wait);
    end
    clear_inputs();
    #1 rst = 1;
  endtask

  task automatic test_single_requester();
    do_reset();
    req1 = 1; rd1 = 1; addr1 = 16'h0010;
    #1;
    n_vec++;
    if ({gnt1, stall1, m_rd} !== 3'b010) begin
      n_err++;
      $display("FAIL single_pre: gnt1/stall1/m_rd=%b want 010", {gnt1, stall1, m_rd});
    end
    tick();
    n_vec++;
    if ({gnt0, gnt1, stall1, m_rd} !== 4'b0101 || m_addr !== 16'h0010) begin
      n_err++;
      $display("FAIL single_grant: gnt0/gnt1/stall1/m_rd=%b m_addr=%h want 0101 0010",
               {gnt0, gnt1, stall1, m_rd}, m_addr);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    int quiet;
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    n_vec++;
    if ({gnt0, gnt1, stall1} !== 3'b101) begin
      n_err++;
      $display("FAIL tie_first: gnt0/gnt1/stall1=%b want 101", {gnt0, gnt1, stall1});
    end
    repeat (5) tick();
    req0 = 0;
    n = 0;
    quiet = 0;
    while (!gnt1 && n < 20) begin
      tick();
      n++;
      if (!gnt0 && !gnt1) quiet++;
    end
    n_vec++;
    if (n !== 6 || quiet !== 5) begin
      n_err++;
      $display("FAIL tie_handover: cycles=%0d quiet=%0d want 6 5", n, quiet);
    end
    n_vec++;
    if ({gnt1, stall1} !== 2'b10) begin
      n_err++;
      $display("FAIL tie_second: gnt1/stall1=%b want 10", {gnt1, stall1});
    end
`ifdef MEM_ARB_PERF_CNT_EN
    n_vec++;
    if (cnt_grant !== 16'd2 || cnt_wait !== 16'd12) begin
      n_err++;
      $display("FAIL tie_counters: grant=%0d wait=%0d want 2 12", cnt_grant, cnt_wait);
    end
`else
    n_vec++;
    if (cnt_grant !== '0 || cnt_wait !== '0) begin
      n_err++;
      $display("FAIL tie_counters_off: grant=%0d wait=%0d want 0 0", cnt_grant, cnt_wait);
    end
`endif
  endtask

  task automatic test_drain_busy();
    int bad;
    do_reset();
    req0 = 1;
    tick();
    req0 = 0; req1 = 1; m_busy = 4'b0100;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt0 || gnt1) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL drain_busy_hold: granted in %0d busy cycles want 0", bad);
    end
    m_busy = 4'b0000;
    tick();
    n_vec++;
    if (gnt1 !== 1'b0) begin
      n_err++;
      $display("FAIL drain_busy_idle: gnt1=%b want 0", gnt1);
    end
    tick();
    n_vec++;
    if (gnt1 !== 1'b1) begin
      n_err++;
      $display("FAIL drain_busy_release: gnt1=%b want 1", gnt1);
    end
  endtask

  task automatic test_isolation();
    do_reset();
    req0 = 1;
    tick();
    addr0 = 16'h0200; wdata0 = 16'hBEEF; wr0 = 1;
    req1 = 1; wr1 = 1; addr1 = 16'h0300; wdata1 = 16'h1111; rd1 = 1;
    #1;
    n_vec++;
    if (m_addr !== 16'h0200 || m_data_in !== 16'hBEEF ||
        {m_wr, m_rd, stall0, stall1, gnt0, gnt1} !== 6'b100110) begin
      n_err++;
      $display("FAIL isolation: m_addr=%h m_data_in=%h wr/rd/st0/st1/g0/g1=%b want 0200 beef 100110",
               m_addr, m_data_in, {m_wr, m_rd, stall0, stall1, gnt0, gnt1});
    end
    m_stall = 1;
    tick();
    n_vec++;
    if ({gnt0, gnt1, stall0, stall1} !== 4'b1011) begin
      n_err++;
      $display("FAIL mstall_forward: g0/g1/st0/st1=%b want 1011", {gnt0, gnt1, stall0, stall1});
    end
  endtask

  task automatic test_error_routing();
    do_reset();
    req1 = 1;
    tick();
    m_err = 1;
    #1;
    n_vec++;
    if ({err0, err1} !== 2'b01) begin
      n_err++;
      $display("FAIL err_owner1: err0/err1=%b want 01", {err0, err1});
    end
    m_err = 0;
    do_reset();
    req0 = 1;
    tick();
    req0 = 0;
    tick();
    m_err = 1;
    #1;
    n_vec++;
    if ({err0, err1, gnt0} !== 3'b100) begin
      n_err++;
      $display("FAIL err_drain0: err0/err1/gnt0=%b want 100", {err0, err1, gnt0});
    end
    m_err = 0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1;
    tick();
    rd0 = 1; req1 = 1;
    #1;
    n_vec++;
    if ({gnt0, m_rd, stall1} !== 3'b111) begin
      n_err++;
      $display("FAIL midrst_pre: gnt0/m_rd/stall1=%b want 111", {gnt0, m_rd, stall1});
    end
    rst = 0;
    #1;
    n_vec++;
    if ({gnt0, m_rd, stall0, stall1} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_async: gnt0/m_rd/stall0/stall1=%b want 0000",
               {gnt0, m_rd, stall0, stall1});
    end
    req0 = 0; rd0 = 0;
    tick();
    rst = 1;
    tick();
    n_vec++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_regrant: gnt0/gnt1=%b want 01", {gnt0, gnt1});
    end
  endtask

  // ---------------- randomized run vs behavioural model ----------------
  // Model: owner is -1 when nobody holds the memory; quiet counts the
  // cycles the memory has been released.
  task automatic test_random();
    int         owner;
    bit         draining;
    int         quiet;
    bit         last;
    int         grants;
    int         waits;
    logic [5:0] e_ctl;
    logic [33:0] e_bus;
    bit         e_g0, e_g1, e_s0, e_s1, e_e0, e_e1;
    do_reset();
    owner = -1; draining = 0; quiet = 0; last = 1; grants = 0; waits = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      rd0 = 1'($urandom_range(1)); wr0 = ~rd0 & 1'($urandom_range(1));
      rd1 = 1'($urandom_range(1)); wr1 = ~rd1 & 1'($urandom_range(1));
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      m_data_out = 16'($urandom);
      m_busy  = ($urandom_range(3) == 0) ? 4'(1 << $urandom_range(3)) : 4'h0;
      m_stall = ($urandom_range(3) == 0);
      m_err   = ($urandom_range(7) == 0);
      @(negedge clk);

      e_g0 = (owner == 0);
      e_g1 = (owner == 1);
      e_s0 = (owner == 0) ? m_stall : req0;
      e_s1 = (owner == 1) ? m_stall : req1;
      e_e0 = ((owner == 0) || (draining && last == 0)) ? m_err : 1'b0;
      e_e1 = ((owner == 1) || (draining && last == 1)) ? m_err : 1'b0;
      e_ctl = {e_g0, e_g1, e_s0, e_s1, e_e0, e_e1};
      if (owner == 0)      e_bus = {addr0, wdata0, wr0, rd0};
      else if (owner == 1) e_bus = {addr1, wdata1, wr1, rd1};
      else                 e_bus = '0;

      n_vec++;
      if ({gnt0, gnt1, stall0, stall1, err0, err1} !== e_ctl) begin
        n_err++;
        $display("FAIL rand_ctl cyc %0d: g0/g1/s0/s1/e0/e1=%b want %b",
                 cyc, {gnt0, gnt1, stall0, stall1, err0, err1}, e_ctl);
      end
      n_vec++;
      if ({m_addr, m_data_in, m_wr, m_rd} !== e_bus) begin
        n_err++;
        $display("FAIL rand_bus cyc %0d: got %h want %h",
                 cyc, {m_addr, m_data_in, m_wr, m_rd}, e_bus);
      end
      n_vec++;
      if (rdata !== m_data_out) begin
        n_err++;
        $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, rdata, m_data_out);
      end
`ifdef MEM_ARB_PERF_CNT_EN
      n_vec++;
      if (cnt_grant !== CNT_W'(grants) || cnt_wait !== CNT_W'(waits)) begin
        n_err++;
        $display("FAIL rand_cnt cyc %0d: grant=%0d wait=%0d want %0d %0d",
                 cyc, cnt_grant, cnt_wait, grants, waits);
      end
`else
      n_vec++;
      if (cnt_grant !== '0 || cnt_wait !== '0) begin
        n_err++;
        $display("FAIL rand_cnt_off cyc %0d: grant=%0d wait=%0d want 0 0",
                 cyc, cnt_grant, cnt_wait);
      end
`endif

      // Advance the model by one clock using this cycle's inputs.
      if ((req0 && e_s0 && !e_g0) || (req1 && e_s1 && !e_g1)) waits++;
      if (owner >= 0) begin
        if ((owner == 0 && !req0) || (owner == 1 && !req1)) begin
          last = owner[0];
          owner = -1;
          draining = 1;
          quiet = 0;
        end
      end else if (draining) begin
        if (quiet >= DRAIN_CYC - 1 && m_busy == 4'h0) draining = 0;
        else quiet++;
      end else if (req0 || req1) begin
        if (req0 && req1) owner = last ? 0 : 1;
        else owner = req0 ? 0 : 1;
        grants++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_single_requester();
    test_simultaneous();
    test_drain_busy();
    test_isolation();
    test_error_routing();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
